// File: rtl/jedro_1_lsu.sv
// ---------------------------------------------------------------------------
// jedro_1_lsu -- load-store unit of the jedro_1 core.
//
// Takes one load/store command at a time from the execute stage, runs the
// req/gnt/rvalid data-bus handshake and returns extended load data or a
// misaligned / bus-error flag together with a one-cycle done pulse.
//
// Handshake: a core command is transferred on a rising edge where
// req_i=1 and ready_o=1. A bus request is transferred on a rising edge
// where data_req_o=1 and data_gnt_i=1. The response is taken on the first
// rising edge after the grant where data_rvalid_i=1.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_i/we_i/size_i/unsigned_i  core command (valid, store, size, zext)
//   addr_i/wdata_i                byte address, right-aligned store data
//   ready_o/done_o                idle indicator, completion pulse
//   rdata_o                       extended load result (successful loads)
//   misaligned_o/err_o            completion status flags
//   data_*                        external data bus (req/gnt/rvalid)
// ---------------------------------------------------------------------------
module jedro_1_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    mis_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    // Decode of the incoming command
    logic                    mis_in;
    logic [3:0]              be_in;
    logic [DATA_WIDTH-1:0]   wdata_in;
    logic                    accept;

    assign accept = (state_q == S_IDLE) && req_i;

    always_comb begin
        mis_in   = 1'b0;
        be_in    = 4'b1111;
        wdata_in = wdata_i;
        case (size_i)
            2'b00: begin
                be_in    = 4'b0001 << addr_i[1:0];
                wdata_in = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                mis_in   = addr_i[0];
                be_in    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{wdata_i[15:0]}};
            end
            default: begin
                // size 11 behaves exactly like a word access
                mis_in = |addr_i[1:0];
            end
        endcase
    end

    // Load extraction: pick the lane by the stored byte offset, then extend
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    always_comb begin
        ld_byte = 8'h00;
        case (off_q)
            2'd0:    ld_byte = data_rdata_i[7:0];
            2'd1:    ld_byte = data_rdata_i[15:8];
            2'd2:    ld_byte = data_rdata_i[23:16];
            default: ld_byte = data_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_ext = data_rdata_i;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_i) state_d = mis_in ? S_DONE : S_REQ;
            S_REQ:  if (data_gnt_i) state_d = S_WAIT;
            S_WAIT: if (data_rvalid_i) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= we_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                off_q   <= addr_i[1:0];
                addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                be_q    <= be_in;
                wdata_q <= wdata_in;
                mis_q   <= mis_in;
                err_q   <= 1'b0;
            end
            if (state_q == S_WAIT && data_rvalid_i) begin
                err_q <= data_err_i;
                // rdata only moves on an error-free load
                if (!we_q && !data_err_i) rdata_q <= ld_ext;
            end
        end
    end

    // Bus fields come straight from registers, so they are stable in REQ
    assign ready_o      = (state_q == S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign misaligned_o = (state_q == S_DONE) && mis_q;
    assign err_o        = (state_q == S_DONE) && err_q;
    assign rdata_o      = rdata_q;
    assign data_req_o   = (state_q == S_REQ);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_jedro_1_lsu.sv
module tb_jedro_1_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, done_o, misaligned_o, err_o;
    logic [31:0] rdata_o;
    logic        data_req_o, data_we_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [31:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_rdata = '0;

    jedro_1_lsu dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
        .rdata_o(rdata_o), .misaligned_o(misaligned_o), .err_o(err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one command end to end, acting as the bus. Expected values come
    // from the access rules: width in bytes, offset, mask and extend.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly,
                          input logic [31:0] bus_rdata, input logic bus_err,
                          output logic [3:0] obs_be, output logic obs_mis);
        int          nbytes, off, bits;
        logic        mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, v, mask;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off    = int'(addr % 4);
        mis    = (addr % nbytes) != 0;
        e_be   = 4'(((1 << nbytes) - 1) << off);
        e_wdata = (nbytes == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                  (nbytes == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
        obs_be = 4'h0;
        obs_mis = 1'b0;
        chk("ready_before", 32'(ready_o), 32'd1);
        req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
        addr_i = addr; wdata_i = wdata;
        tick();
        req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
        if (mis) begin
            chk("mis_done", 32'(done_o), 32'd1);
            chk("mis_flag", 32'(misaligned_o), 32'd1);
            chk("mis_req", 32'(data_req_o), 32'd0);
            chk("mis_err", 32'(err_o), 32'd0);
            obs_mis = misaligned_o;
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                chk("req", 32'(data_req_o), 32'd1);
                chk("addr", data_addr_o, {addr[31:2], 2'b00});
                chk("be", 32'(data_be_o), 32'(e_be));
                chk("we", 32'(data_we_o), 32'(we));
                chk("wdata", data_wdata_o, e_wdata);
                chk("done_in_req", 32'(done_o), 32'd0);
                obs_be = data_be_o;
                data_gnt_i = (i == gnt_dly);
                // rvalid must be ignored while the request is pending
                data_rvalid_i = (i == gnt_dly) ? 1'b0 : 1'($urandom_range(0, 1));
                data_rdata_i = $urandom;
                data_err_i = 1'($urandom_range(0, 1));
                tick();
            end
            data_gnt_i = 1'b0;
            for (int i = 0; i <= rv_dly; i++) begin
                chk("req_in_wait", 32'(data_req_o), 32'd0);
                chk("done_in_wait", 32'(done_o), 32'd0);
                data_rvalid_i = (i == rv_dly);
                data_rdata_i = (i == rv_dly) ? bus_rdata : $urandom;
                data_err_i = (i == rv_dly) ? bus_err : 1'($urandom_range(0, 1));
                tick();
            end
            data_rvalid_i = 1'b0; data_err_i = 1'b0;
            if (!we && !bus_err) begin
                bits = 8 * nbytes;
                v = bus_rdata >> (8 * off);
                if (nbytes < 4) begin
                    mask = (32'd1 << bits) - 32'd1;
                    v = v & mask;
                    if (!uns && v[bits-1]) v = v | ~mask;
                end
                model_rdata = v;
            end
            chk("done", 32'(done_o), 32'd1);
            chk("err", 32'(err_o), 32'(bus_err));
            chk("mis_clear", 32'(misaligned_o), 32'd0);
        end
        chk("ready_in_done", 32'(ready_o), 32'd0);
        chk("rdata", rdata_o, model_rdata);
        tick();
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("ready_after", 32'(ready_o), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] bus_rdata;
        logic        bus_err;
        logic [3:0]  exp_be;
        logic        exp_mis;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [3:0] obe;
        logic       omis;
        // Directed vectors; rdata expectations follow from the running sequence
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 0, 0, 32'h8012_3456, 1'b0, 4'b1000, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 1, 0, 32'h8012_3456, 1'b0, 4'b1000, 1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_ABCD, 3, 1, 32'h0, 1'b0, 4'b1100, 1'b0, 32'h0000_0080};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h0000_0080};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h0000_0080};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 0, 2, 32'h8001_7FFF, 1'b0, 4'b1100, 1'b0, 32'hFFFF_8001};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, 32'hFFFF_8001};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 2, 0, 32'h0000_AB00, 1'b0, 4'b0010, 1'b0, 32'h0000_00AB};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0, 4'b1111, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h1234_56A5, 1, 1, 32'h0, 1'b0, 4'b0010, 1'b0, 32'hCAFE_F00D};

        // Reset state
        #12;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_we", 32'(data_we_o), 32'd0);
        chk("rst_flags", {30'd0, misaligned_o, err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tick();

        // Table-driven directed vectors
        foreach (vecs[k]) begin
            do_txn(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata,
                   vecs[k].gnt_dly, vecs[k].rv_dly, vecs[k].bus_rdata, vecs[k].bus_err, obe, omis);
            chk($sformatf("vec%0d_mis", k), 32'(omis), 32'(vecs[k].exp_mis));
            if (!vecs[k].exp_mis) chk($sformatf("vec%0d_be", k), 32'(obe), 32'(vecs[k].exp_be));
            chk($sformatf("vec%0d_rdata", k), rdata_o, vecs[k].exp_rdata);
        end

        // Ignored request while busy: second req during REQ must not be taken
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h0000_0200;
        tick();
        addr_i = 32'h0000_0300;
        chk("busy_addr", data_addr_o, 32'h0000_0200);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0; req_i = 1'b0;
        chk("busy_addr_hold", data_addr_o, 32'h0000_0200);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_F00D;
        tick();
        data_rvalid_i = 1'b0;
        model_rdata = 32'h0BAD_F00D;
        chk("busy_done", 32'(done_o), 32'd1);
        chk("busy_rdata", rdata_o, model_rdata);
        tick();

        // Randomized commands against the reference model
        for (int n = 0; n < 300; n++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, ($urandom_range(0, 7) == 0), obe, omis);
        end

        // Reset while in REQ: request drops without a clock edge
        req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; addr_i = 32'h0000_0400;
        tick();
        req_i = 1'b0;
        chk("rreq_req", 32'(data_req_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rreq_req_drop", 32'(data_req_o), 32'd0);
        chk("rreq_ready", 32'(ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        model_rdata = '0;
        tick();

        // Reset while in WAIT, then a late rvalid
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h0000_0500;
        tick();
        req_i = 1'b0; data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("rwait_ready_pre", 32'(ready_o), 32'd0);
        #2 rst_i = 1'b1;
        #1;
        chk("rwait_req", 32'(data_req_o), 32'd0);
        chk("rwait_ready", 32'(ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        tick();
        data_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rv_done", 32'(done_o), 32'd0);
            chk("late_rv_ready", 32'(ready_o), 32'd1);
            tick();
        end
        chk("late_rv_rdata", rdata_o, model_rdata);

        // Normal operation after reset
        do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0602, 32'h0, 0, 0, 32'hF00F_1234, 1'b0, obe, omis);
        chk("post_rst_rdata", rdata_o, 32'h0000_F00F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load-store unit of the jedro_1 core. It sits between the execute stage and the core's external data interface. It takes one load/store command at a time from the core, runs the req/gnt/rvalid bus handshake, and aligns byte enables and write data. It then returns sign- or zero-extended load data, or a misalignment or bus-error flag.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address width.

Ports:
clk_i  in  1  core clock; all state updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
req_i  in  1  core command valid; accepted only when ready_o=1.
we_i  in  1  1 = store, 0 = load.
size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
addr_i  in  ADDR_WIDTH  byte address.
wdata_i  in  DATA_WIDTH  store data, right-aligned.
ready_o  out  1  LSU is idle and can accept a command.
done_o  out  1  one-cycle pulse: command finished (success, misaligned or error).
rdata_o  out  DATA_WIDTH  extended load result; valid with done_o for loads.
misaligned_o  out  1  pulse with done_o: address misaligned, no bus access made.
err_o  out  1  pulse with done_o: data_err_i was returned.
data_req_o  out  1  bus request.
data_gnt_i  in  1  bus grant.
data_rvalid_i  in  1  response valid.
data_we_o  out  1  bus write enable.
data_be_o  out  4  byte enables.
data_addr_o  out  ADDR_WIDTH  word-aligned address.
data_wdata_o  out  DATA_WIDTH  replicated write data.
data_rdata_i  in  DATA_WIDTH  bus read data.
data_err_i  in  1  bus error, qualified by data_rvalid_i.

Behaviour:
- Reset values: state IDLE; ready_o=1; all other outputs 0, including rdata_o and data_*_o. Reset asserted mid-transaction drops data_req_o immediately (asynchronously) and discards the command. No done_o is produced for it.
- States and transitions:
  - IDLE: ready_o=1. req_i=1 registers the command.
  - Misaligned command (half with addr[0]=1, or word with addr[1:0]≠0): go to DONE with misaligned_o set.
  - Aligned command: go to REQ.
- REQ: data_req_o=1, and data_addr_o/data_we_o/data_be_o/data_wdata_o are held stable until data_gnt_i=1. On grant, go to WAIT. data_rvalid_i is ignored in REQ.
- WAIT: data_req_o=0. On data_rvalid_i=1, capture data_rdata_i and data_err_i, then go to DONE. Grant and rvalid never overlap for the same transaction, so exactly one transaction is ever outstanding.
- DONE: one cycle. done_o=1, with misaligned_o/err_o as captured. Then return to IDLE; ready_o=0 in DONE.
- Minimum latency: accept at cycle 0, data_req_o at cycle 1, gnt at cycle 1, rvalid at cycle 2, done_o at cycle 3. Misaligned command: done_o at cycle 1.
- data_addr_o = {addr[31:2], 2'b00}.
- data_be_o:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - word: 4'b1111.
- data_wdata_o:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction: select the byte or half by addr[1:0], then sign- or zero-extend per unsigned_i to 32 bits.
- rdata_o updates only on a successful load. It holds its value after stores, errors and misaligned commands; it is 0 after reset.
- Load with data_err_i=1: err_o=1, rdata_o unchanged.
- Store completion also waits for data_rvalid_i. rdata_o is not modified by a store.
- req_i while ready_o=0 is ignored; the core must hold it.

Test Plan:
- Word load at 0x0000_1004, gnt on the first cycle, rvalid one cycle later with 0xDEADBEEF -> data_addr_o=0x1004, be=1111, done_o at cycle 3, rdata_o=0xDEADBEEF.
- Signed byte load at addr 0x...03, rdata_i=0x80_12_34_56 -> be=1000, rdata_o=0xFFFFFF80. Same load with unsigned_i=1 -> rdata_o=0x00000080.
- Half store of 0x0000ABCD at addr 0x...02, gnt held low for 3 cycles -> data_req_o and the address/be/wdata stay stable for 4 cycles, be=1100, wdata=0xABCDABCD; done_o follows rvalid by one cycle.
- Word load at 0x...01 -> no data_req_o; done_o and misaligned_o pulse at cycle 1. Half at 0x...01 behaves the same way; half at 0x...02 is legal.
- Load with rvalid and data_err_i=1 -> err_o=1 with done_o; rdata_o keeps its previous value; ready_o returns to 1 the next cycle.
- Assert rst_i while in WAIT -> data_req_o=0 and ready_o=1 immediately. A late rvalid after reset release produces no done_o.
